// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel and data-memory bus of the load/store unit.
// master = pipeline plus memory side, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_fault;

    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_re, mem_we, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_re, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-enabled word accesses; misaligned split needs LSU_MISALIGN_SPLIT_EN.
// Latency: resp_valid 2 cycles after accept, 3 when an access is split into two words.
// Backpressure: req_ready only in IDLE, one request in flight; responses cannot be stalled.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    localparam int WI = DM_ADDRESS - 2;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     lo_word;

    logic                  resp_valid_q;
    logic [DATA_W-1:0]     resp_rdata_q;
    logic                  resp_fault_q;

    logic [2:0]            size;
    logic                  illegal;
    logic [1:0]            ofs;
    logic                  split;
    logic                  fault;
    logic [7:0]            mask;
    logic [2*DATA_W-1:0]   wdata_sh;
    logic [WI-1:0]         widx;
    logic [WI-1:0]         widx_inc;
    logic [2*DATA_W-1:0]   pair;
    logic [DATA_W-1:0]     ld_word;
    logic [DATA_W-1:0]     ld_val;

    logic [DM_ADDRESS-1:0] acc_addr;
    logic                  acc_re;
    logic                  acc_we;
    logic [3:0]            acc_be;
    logic [DATA_W-1:0]     acc_wdata;

    always_comb begin
        size    = 3'd1;
        illegal = 1'b0;
        case (r_funct3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        illegal = 1'b1;
        endcase
    end

    assign ofs      = r_addr[1:0];
    assign split    = ({1'b0, ofs} + size) > 3'd4;
    assign fault    = illegal | (split & ~SPLIT_EN);
    // 8-bit lane mask across the two words touched; upper nibble only used by ACC1
    assign mask     = ((8'd1 << size) - 8'd1) << ofs;
    assign wdata_sh = {{DATA_W{1'b0}}, r_wdata} << {ofs, 3'b000};
    assign widx     = r_addr[DM_ADDRESS-1:2];
    assign widx_inc = widx + WI'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_addr  = '0;
        acc_re    = 1'b0;
        acc_we    = 1'b0;
        acc_be    = 4'b0000;
        acc_wdata = '0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = ACC0;
                end
            end
            ACC0: begin
                if (fault) begin
                    state_nxt = DONE;
                end else begin
                    acc_addr  = {widx, 2'b00};
                    acc_be    = mask[3:0];
                    acc_wdata = wdata_sh[DATA_W-1:0];
                    acc_re    = ~r_we;
                    acc_we    = r_we;
                    state_nxt = split ? ACC1 : DONE;
                end
            end
            ACC1: begin
                acc_addr  = {widx_inc, 2'b00};
                acc_be    = mask[7:4];
                acc_wdata = wdata_sh[2*DATA_W-1:DATA_W];
                acc_re    = ~r_we;
                acc_we    = r_we;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // In DONE, mem_rdata carries the last word read: the high word when split, else the only word
    assign pair    = split ? {bus.mem_rdata, lo_word} : {{DATA_W{1'b0}}, bus.mem_rdata};
    assign ld_word = DATA_W'(pair >> {ofs, 3'b000});

    always_comb begin
        case (r_funct3)
            3'b000:  ld_val = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_val = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_val = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
            3'b101:  ld_val = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            lo_word      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (state == IDLE && bus.req_valid) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (state == ACC1 && !r_we) begin
                lo_word <= bus.mem_rdata;
            end
            if (state == DONE) begin
                resp_valid_q <= 1'b1;
                resp_fault_q <= fault;
                resp_rdata_q <= (fault || r_we) ? '0 : ld_val;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_addr   = acc_addr;
    assign bus.mem_re     = acc_re;
    assign bus.mem_we     = acc_we;
    assign bus.mem_be     = acc_be;
    assign bus.mem_wdata  = acc_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests, expected responses and memory accesses queued.
module tb_load_store_unit;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [31:0] RST_ADDR = 32'h020;
`else
    localparam logic [31:0] RST_ADDR = 32'h010;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

    load_store_unit #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    resp_t       resp_q[$];
    acc_t        acc_q[$];
    resp_t       r_exp;
    acc_t        a_exp;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mem [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide memory with one-cycle read latency; contents restored on reset
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[4]        <= 32'hDEADBEEF;
            mem[7]        <= 32'h44332211;
            mem[8]        <= 32'h88776655;
            bus.mem_rdata <= 32'h0;
        end else begin
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
            if (bus.mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be[i]) mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic exp_acc(input logic we, input logic [8:0] addr, input logic [3:0] be, input logic [31:0] wd);
        acc_q.push_back('{we, addr, be, wd});
    endtask

    // lat = 0 means no response is expected
    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_f, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: ready=%0b expected 1 within 20 cycles", bus.req_ready);
        end else begin
            bus.req_valid  = 1'b1;
            bus.req_we     = we;
            bus.req_funct3 = f3;
            bus.req_addr   = addr;
            bus.req_wdata  = wd;
            if (lat > 0) resp_q.push_back('{exp_rd, exp_f, cyc + 1 + lat});
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: rdata=0x%08h fault=%0b with no response pending", bus.resp_rdata, bus.resp_fault);
                end else begin
                    r_exp = resp_q.pop_front();
                    check("resp_rdata", bus.resp_rdata, r_exp.rdata);
                    check("resp_fault", 32'(bus.resp_fault), 32'(r_exp.fault));
                    check("resp_cycle", 32'(cyc), 32'(r_exp.cyc));
                end
            end
            if (bus.mem_re || bus.mem_we) begin
                check("strobe_exclusive", 32'(bus.mem_re & bus.mem_we), 32'h0);
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: we=%0b addr=0x%03h be=%b with no access pending", bus.mem_we, bus.mem_addr, bus.mem_be);
                end else begin
                    a_exp = acc_q.pop_front();
                    check("acc_we", 32'(bus.mem_we), 32'(a_exp.we));
                    check("acc_addr", 32'(bus.mem_addr), 32'(a_exp.addr));
                    check("acc_be", 32'(bus.mem_be), 32'(a_exp.be));
                    if (a_exp.we) check("acc_wdata", bus.mem_wdata, a_exp.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_fault", 32'(bus.resp_fault), 32'h0);
        check("rst_mem_re", 32'(bus.mem_re), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_be", 32'(bus.mem_be), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Aligned and non-split accesses
        exp_acc(1'b0, 9'h010, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        exp_acc(1'b1, 9'h010, 4'b1111, 32'h80000000);
        issue(1'b1, 3'b010, 9'h010, 32'h80000000, 32'h0, 1'b0, 2);
        exp_acc(1'b0, 9'h010, 4'b1000, 32'h0);
        issue(1'b0, 3'b000, 9'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        exp_acc(1'b0, 9'h010, 4'b1000, 32'h0);
        issue(1'b0, 3'b100, 9'h013, 32'h0, 32'h00000080, 1'b0, 2);
        exp_acc(1'b1, 9'h000, 4'b1100, 32'hABCD0000);
        issue(1'b1, 3'b001, 9'h002, 32'h1234ABCD, 32'h0, 1'b0, 2);
        exp_acc(1'b0, 9'h01C, 4'b1100, 32'h0);
        issue(1'b0, 3'b001, 9'h01E, 32'h0, 32'h00004433, 1'b0, 2);
        exp_acc(1'b0, 9'h020, 4'b1100, 32'h0);
        issue(1'b0, 3'b101, 9'h022, 32'h0, 32'h00008877, 1'b0, 2);
        exp_acc(1'b0, 9'h020, 4'b1100, 32'h0);
        issue(1'b0, 3'b001, 9'h022, 32'h0, 32'hFFFF8877, 1'b0, 2);

        // Misaligned accesses crossing a word boundary, including the wrap to word 0
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_acc(1'b0, 9'h01C, 4'b1100, 32'h0);
        exp_acc(1'b0, 9'h020, 4'b0011, 32'h0);
        issue(1'b0, 3'b010, 9'h01E, 32'h0, 32'h66554433, 1'b0, 3);
        exp_acc(1'b0, 9'h01C, 4'b1000, 32'h0);
        exp_acc(1'b0, 9'h020, 4'b0001, 32'h0);
        issue(1'b0, 3'b101, 9'h01F, 32'h0, 32'h00005544, 1'b0, 3);
        exp_acc(1'b1, 9'h1FC, 4'b1110, 32'hFEF00D00);
        exp_acc(1'b1, 9'h000, 4'b0001, 32'h000000CA);
        issue(1'b1, 3'b010, 9'h1FD, 32'hCAFEF00D, 32'h0, 1'b0, 3);
        exp_acc(1'b0, 9'h1FC, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h1FC, 32'h0, 32'hFEF00D00, 1'b0, 2);
        exp_acc(1'b0, 9'h000, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h000, 32'h0, 32'hABCD00CA, 1'b0, 2);
        exp_acc(1'b0, 9'h000, 4'b0001, 32'h0);
        issue(1'b0, 3'b000, 9'h000, 32'h0, 32'hFFFFFFCA, 1'b0, 2);
`else
        issue(1'b0, 3'b010, 9'h01E, 32'h0, 32'h0, 1'b1, 2);
        issue(1'b0, 3'b101, 9'h01F, 32'h0, 32'h0, 1'b1, 2);
        issue(1'b1, 3'b010, 9'h1FD, 32'hCAFEF00D, 32'h0, 1'b1, 2);
        exp_acc(1'b0, 9'h1FC, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h1FC, 32'h0, 32'h0, 1'b0, 2);
        exp_acc(1'b0, 9'h000, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h000, 32'h0, 32'hABCD0000, 1'b0, 2);
        exp_acc(1'b0, 9'h000, 4'b0001, 32'h0);
        issue(1'b0, 3'b000, 9'h000, 32'h0, 32'h0, 1'b0, 2);
`endif

        // Illegal funct3: no strobes, fault response
        issue(1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 2);
        issue(1'b1, 3'b110, 9'h010, 32'h12345678, 32'h0, 1'b1, 2);

        // Reset in the middle of an operation: abandoned with no response
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_acc(1'b0, 9'h01C, 4'b1100, 32'h0);
        issue(1'b0, 3'b010, 9'h01E, 32'h0, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
`else
        issue(1'b0, 3'b010, 9'h010, 32'h0, 32'h0, 1'b0, 0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_busy_re", 32'(bus.mem_re), 32'h1);
        check("rstmid_busy_addr", 32'(bus.mem_addr), RST_ADDR);
        @(negedge clk);
        check("rstmid_req_ready", 32'(bus.req_ready), 32'h1);
        check("rstmid_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rstmid_resp_rdata", bus.resp_rdata, 32'h0);
        check("rstmid_mem_re", 32'(bus.mem_re), 32'h0);
        check("rstmid_mem_we", 32'(bus.mem_we), 32'h0);
        check("rstmid_mem_be", 32'(bus.mem_be), 32'h0);
        check("rstmid_mem_addr", 32'(bus.mem_addr), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        exp_acc(1'b0, 9'h010, 4'b1111, 32'h0);
        issue(1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        for (int i = 0; i < 50 && (resp_q.size() != 0 || acc_q.size() != 0); i++) @(negedge clk);
        check("drain_resp_pending", 32'(resp_q.size()), 32'h0);
        check("drain_acc_pending", 32'(acc_q.size()), 32'h0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
